gamma_lut_prog: RTL
===================

// Module: gamma_lut_prog
// PURPOSE
//  Programmable gamma curve: the writer side that fills the 256-entry gamma table the pixel path reads.
//  Config port streams 256 bytes into a shadow bank; the shadow bank swaps to active at the next frame start.
//  Pixel path looks up one 8-bit sample per cycle with fixed 2-cycle latency; sync/enable are delayed to match.
//  Sits in the ISP pipeline after CCM, before YUV conversion; tables are loaded by the host via config bridge.
// PARAMETERS
//  DATA_W     8   pixel and table entry width (table depth = 2**DATA_W = 256)
//  VSYNC_POL  1   1: frame start = rising edge of in_vsync; 0: falling edge
// PORTS
//  clk         in   1       pixel/config clock
//  rst_n       in   1       asynchronous reset, active low
//  cfg_start   in   1       pulse: begin loading a new table into shadow bank
//  cfg_valid   in   1       config byte valid
//  cfg_ready   out  1       config byte accepted when cfg_valid & cfg_ready
//  cfg_data    in   DATA_W  table entry, entries sent in address order 0..255
//  cfg_last    in   1       marks entry 255
//  load_done   out  1       1-cycle pulse: table swapped into active bank
//  load_err    out  1       1-cycle pulse: load aborted (framing or monotonic error)
//  table_vld   out  1       1 once any table has been swapped in; 0 => bypass
//  in_vsync    in   1       frame sync
//  in_href     in   1       line valid
//  in_data     in   DATA_W  pixel sample
//  out_vsync   out  1       in_vsync delayed 2 cycles
//  out_href    out  1       in_href delayed 2 cycles
//  out_data    out  DATA_W  gamma(in_data) or in_data when table_vld=0, 2-cycle latency
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, wr_addr 0, active bank 0, table_vld 0; RAM contents not reset.
//  FSM: IDLE --cfg_start--> LOAD --256th byte with cfg_last--> ARMED --frame start--> IDLE (swap).
//  LOAD: cfg_ready=1; each accepted byte writes shadow[wr_addr], wr_addr++.
//  cfg_last on byte <255, or byte 255 without cfg_last: load_err pulse, shadow discarded, -> IDLE.
//  cfg_start in LOAD or ARMED: restart LOAD at wr_addr 0, pending swap cancelled, no err pulse.
//  cfg_ready=0 in IDLE/ARMED; bytes offered then are ignored.
//  ARMED: swap on frame-start edge detected in a cycle after ARMED entry; edge in same cycle as final
//   byte does not swap (waits one frame). Swap: active bank toggles, table_vld<=1, load_done pulses.
//  Lookup: stage1 registers in_data/bank select; stage2 registers RAM read; bank select sampled in
//   stage1 so a swap never splits a pixel's read. Bypass path uses same 2-cycle delay.
//  Frame-start edge detector uses a registered in_vsync (reset 0); first cycle after reset never swaps.
//  Reset mid-load: async clear, table_vld=0, output returns to bypass.
// CONFIGURATION
//  GAMMA_MONO_CHECK_EN defined: during LOAD each byte must be >= previous accepted byte; violation
//   -> load_err pulse, abort to IDLE, shadow discarded (remaining bytes ignored until next cfg_start).
//  Undefined: no ordering check; any 256-byte table accepted.
// STRUCTURE
//  gamma_pkg: LUT_DEPTH=256 constant, state enum {IDLE, LOAD, ARMED}, default DATA_W.
//  Sub-module gamma_lut_bank: 2x256xDATA_W simple dual-port sync RAM (1 write, 1 read, bank-select bit).
//  Top: config FSM, wr_addr counter, vsync edge detect, 2-stage lookup/sync delay pipeline.
// TESTING
//  Post-reset, no load: in_data=8'd100 href=1 -> out_data=8'd100 two cycles later, table_vld=0.
//  Load 256 bytes entry i=255-i(check off)/i(check on); vsync edge -> load_done, in_data=8'd10 -> out 8'd245 / 8'd10.
//  cfg_last on byte 100 -> load_err pulse, cfg_ready=0, table_vld/active table unchanged.
//  Final byte and vsync edge same cycle -> no swap; next vsync edge -> load_done, new table used.
//  GAMMA_MONO_CHECK_EN: bytes 0,5,4 -> load_err on 3rd byte; undefined: same table loads fine.
//  Assert rst_n=0 mid-LOAD at byte 50 -> all outputs 0, bypass after release; cfg_start restarts at addr 0.

Source files
------------

// File: rtl/gamma_pkg.sv
// rtl/gamma_pkg.sv - shared constants and FSM state type for the programmable gamma LUT
package gamma_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int LUT_DEPTH  = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2
  } state_e;

endpackage

// File: rtl/gamma_lut_prog_if.sv
// rtl/gamma_lut_prog_if.sv - config stream, status and pixel stream bundle for gamma_lut_prog
interface gamma_lut_prog_if #(
  parameter int DATA_W = gamma_pkg::DATA_W_DEF
) ();

  logic              cfg_start;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_last;
  logic              load_done;
  logic              load_err;
  logic              table_vld;
  logic              in_vsync;
  logic              in_href;
  logic [DATA_W-1:0] in_data;
  logic              out_vsync;
  logic              out_href;
  logic [DATA_W-1:0] out_data;

  modport master (
    output cfg_start, cfg_valid, cfg_data, cfg_last, in_vsync, in_href, in_data,
    input  cfg_ready, load_done, load_err, table_vld, out_vsync, out_href, out_data
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, cfg_last, in_vsync, in_href, in_data,
    output cfg_ready, load_done, load_err, table_vld, out_vsync, out_href, out_data
  );

endinterface

// File: rtl/gamma_lut_bank.sv
// rtl/gamma_lut_bank.sv - two-bank gamma table RAM, one write port and one registered read port
module gamma_lut_bank #(
  parameter int DATA_W = gamma_pkg::DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              wbank_i,
  input  logic [DATA_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rbank_i,
  input  logic [DATA_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  // Contents are deliberately not reset so this maps onto block RAM.
  logic [DATA_W-1:0] mem [0:(2**(DATA_W+1))-1];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[{wbank_i, waddr_i}] <= wdata_i;
    end
    rdata_o <= mem[{rbank_i, raddr_i}];
  end

endmodule

// File: rtl/gamma_lut_prog.sv
// rtl/gamma_lut_prog.sv - gamma table loader with shadow/active bank swap and 2-cycle lookup
// Optional monotonic table check enabled by defining GAMMA_MONO_CHECK_EN.
module gamma_lut_prog
  import gamma_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  gamma_lut_prog_if.slave  bus
);

  localparam logic [DATA_W-1:0] ADDR_LAST = '1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] wr_addr_q, wr_addr_d;
  logic              bank_q, bank_d;
  logic              tvld_q, tvld_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ready_q;
  logic              vsync_q;
  logic              frame_start;
  logic              accept;
  logic              we;
  logic              mono_err;

  logic              bank_s1, tvld_s1, vs_s1, hr_s1;
  logic [DATA_W-1:0] data_s1;
  logic              tvld_s2, vs_s2, hr_s2;
  logic [DATA_W-1:0] byp_s2;
  logic [DATA_W-1:0] rd_data;

  assign frame_start = VSYNC_POL ? (bus.in_vsync & ~vsync_q) : (~bus.in_vsync & vsync_q);
  assign accept      = bus.cfg_valid & ready_q;
  // A restart request wins over a byte offered in the same cycle; that byte is dropped.
  assign we          = accept & ~bus.cfg_start;

`ifdef GAMMA_MONO_CHECK_EN
  logic [DATA_W-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
    end else if (we) begin
      prev_q <= bus.cfg_data;
    end
  end

  assign mono_err = (wr_addr_q != '0) && (bus.cfg_data < prev_q);
`else
  assign mono_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    bank_d    = bank_q;
    tvld_d    = tvld_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cfg_start) begin
          state_d   = LOAD;
          wr_addr_d = '0;
        end
      end
      LOAD: begin
        if (bus.cfg_start) begin
          wr_addr_d = '0;
        end else if (accept) begin
          if (mono_err || (bus.cfg_last != (wr_addr_q == ADDR_LAST))) begin
            err_d     = 1'b1;
            state_d   = IDLE;
            wr_addr_d = '0;
          end else if (bus.cfg_last) begin
            state_d   = ARMED;
            wr_addr_d = '0;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end
      ARMED: begin
        // An edge coincident with the final byte was seen while still in LOAD, so it never swaps.
        if (bus.cfg_start) begin
          state_d   = LOAD;
          wr_addr_d = '0;
        end else if (frame_start) begin
          state_d = IDLE;
          bank_d  = ~bank_q;
          tvld_d  = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      bank_q    <= 1'b0;
      tvld_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      vsync_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      bank_q    <= bank_d;
      tvld_q    <= tvld_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= (state_d == LOAD);
      vsync_q   <= bus.in_vsync;
    end
  end

  // Bank select and table_vld are captured with the pixel so a swap never splits a lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_s1 <= '0;
      bank_s1 <= 1'b0;
      tvld_s1 <= 1'b0;
      vs_s1   <= 1'b0;
      hr_s1   <= 1'b0;
      byp_s2  <= '0;
      tvld_s2 <= 1'b0;
      vs_s2   <= 1'b0;
      hr_s2   <= 1'b0;
    end else begin
      data_s1 <= bus.in_data;
      bank_s1 <= bank_q;
      tvld_s1 <= tvld_q;
      vs_s1   <= bus.in_vsync;
      hr_s1   <= bus.in_href;
      byp_s2  <= data_s1;
      tvld_s2 <= tvld_s1;
      vs_s2   <= vs_s1;
      hr_s2   <= hr_s1;
    end
  end

  gamma_lut_bank #(.DATA_W(DATA_W)) u_bank (
    .clk     (clk),
    .we_i    (we),
    .wbank_i (~bank_q),
    .waddr_i (wr_addr_q),
    .wdata_i (bus.cfg_data),
    .rbank_i (bank_s1),
    .raddr_i (data_s1),
    .rdata_o (rd_data)
  );

  assign bus.cfg_ready = ready_q;
  assign bus.load_done = done_q;
  assign bus.load_err  = err_q;
  assign bus.table_vld = tvld_q;
  assign bus.out_vsync = vs_s2;
  assign bus.out_href  = hr_s2;
  assign bus.out_data  = tvld_s2 ? rd_data : byp_s2;

endmodule
